// File: rtl/mem_drain_pkg.sv
// Shared types and sizing helpers for the output bank drainer.
package mem_drain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Width needed to hold an occupancy count from 0 to depth inclusive.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/output_bank_drainer_if.sv
// Valid/ready word stream leaving the drainer.
interface output_bank_drainer_if #(
    parameter int WIDTH = 32
);
    logic             m_valid_out;
    logic             m_ready_in;
    logic [WIDTH-1:0] m_data_out;
    logic             m_last_out;

    modport master (output m_valid_out, output m_data_out, output m_last_out, input m_ready_in);
    modport slave  (input m_valid_out, input m_data_out, input m_last_out, output m_ready_in);
endinterface

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with occupancy count; pointers clear asynchronously.
module drain_fifo
    import mem_drain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic [cnt_bits(DEPTH)-1:0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: storage has no reset; only pointers and count are cleared, and
    // the consumer gates the head word with a non-empty count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/output_bank_drainer.sv
// Sweeps an address range through a one-cycle-latency read port and streams the words out in order.
module output_bank_drainer
    import mem_drain_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_in,
    input  logic [RAM_ADDR_BITS-1:0] base_addr_in,
    input  logic [RAM_ADDR_BITS:0]   count_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [RAM_ADDR_BITS-1:0] mem_raddr_out,
    input  logic                     mem_we_in,
    input  logic [RAM_WIDTH-1:0]     mem_rdata_in,
    output_bank_drainer_if.master    m
);
    localparam int CW = cnt_bits(FIFO_DEPTH);
    localparam int NW = RAM_ADDR_BITS + 1;

    state_t                 state;
    logic [NW-1:0]          to_issue;
    logic [NW-1:0]          to_send;
    logic                   inflight;
    logic [CW-1:0]          fifo_count;
    logic [RAM_WIDTH-1:0]   fifo_head;
    logic [CW:0]            used;
    logic                   issue;
    logic                   capture;
    logic                   valid;
    logic                   pop;
    logic                   last;

    // Buffered words plus the one returning from the read port bound new issues.
    assign used    = {1'b0, fifo_count} + (CW+1)'(inflight);
    assign issue   = (state == RUN) && (used < (CW+1)'(FIFO_DEPTH));
    assign capture = issue && !mem_we_in;

    assign valid = (fifo_count != '0);
    assign pop   = valid && m.m_ready_in;
    assign last  = valid && (to_send == NW'(1));

    assign m.m_valid_out = valid;
    assign m.m_data_out  = valid ? fifo_head : '0;
    assign m.m_last_out  = last;

    drain_fifo #(.WIDTH(RAM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight),
        .wdata (mem_rdata_in),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    // NOTE: all state here is sequential and uses non-blocking assignments.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            mem_raddr_out <= '0;
            to_issue      <= '0;
            to_send       <= '0;
            inflight      <= 1'b0;
        end else begin
            done_out <= 1'b0;
            inflight <= capture;
            if (pop) to_send <= to_send - NW'(1);
            case (state)
                IDLE: begin
                    if (start_in) begin
                        busy_out      <= 1'b1;
                        mem_raddr_out <= base_addr_in;
                        to_issue      <= count_in;
                        to_send       <= count_in;
                        if (count_in == '0) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A lost read keeps the address so the same word is retried next cycle.
                    if (capture) begin
                        mem_raddr_out <= mem_raddr_out + RAM_ADDR_BITS'(1);
                        to_issue      <= to_issue - NW'(1);
                        if (to_issue == NW'(1)) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && last) begin
                        state    <= DONE;
                        done_out <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_output_bank_drainer.sv
// Table-driven bench with a word scoreboard and a registered-read memory model.
module tb_output_bank_drainer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start_in;
    logic [9:0]  base_addr_in;
    logic [10:0] count_in;
    logic        busy_out;
    logic        done_out;
    logic [9:0]  mem_raddr_out;
    logic        mem_we_in;
    logic [31:0] mem_rdata_in;

    output_bank_drainer_if #(.WIDTH(32)) sif ();

    output_bank_drainer #(.RAM_WIDTH(32), .RAM_ADDR_BITS(10), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_in      (start_in),
        .base_addr_in  (base_addr_in),
        .count_in      (count_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .mem_raddr_out (mem_raddr_out),
        .mem_we_in     (mem_we_in),
        .mem_rdata_in  (mem_rdata_in),
        .m             (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'(a) * 32'h11;
    endfunction

    // Registered read port; a write cycle corrupts the read result.
    always @(posedge clk) begin
        if (!mem_we_in) mem_rdata_in <= mem_word(mem_raddr_out);
        else            mem_rdata_in <= 32'hDEAD_BEEF;
    end

    typedef struct {
        string       name;
        logic [9:0]  base;
        logic [10:0] count;
        bit          collide;
        logic [9:0]  we_addr;
        int          ready_mode;
        bit          spur;
        int          exp_first;
        int          exp_done;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy_out),         32'd0);
        check({tag, "_done"},  32'(done_out),         32'd0);
        check({tag, "_raddr"}, 32'(mem_raddr_out),    32'd0);
        check({tag, "_valid"}, 32'(sif.m_valid_out),  32'd0);
        check({tag, "_data"},  sif.m_data_out,        32'd0);
        check({tag, "_last"},  32'(sif.m_last_out),   32'd0);
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_cmd(input vec_t v);
        int          cyc;
        int          first_valid = -1;
        int          done_cyc = -1;
        int          beats = 0;
        bit          stalled = 0;
        bit          collided = 0;
        logic [31:0] held = '0;
        logic [9:0]  raddr_seen[4];
        logic [9:0]  a;

        exp_q.delete();
        for (int k = 0; k < int'(v.count); k++) begin
            a = v.base + 10'(k);
            exp_q.push_back(mem_word(a));
        end
        base_addr_in = v.base;
        count_in     = v.count;
        start_in     = 1'b1;
        mem_we_in    = 1'b0;
        sif.m_ready_in = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (done_cyc < 0 && cyc < 80) begin
            if (cyc <= 4) raddr_seen[cyc-1] = mem_raddr_out;
            if (cyc == 1) check({v.name, "_busy_c1"}, 32'(busy_out), 32'd1);
            sif.m_ready_in = (v.ready_mode == 1) ? !(cyc >= 3 && cyc < 8) : 1'b1;
            mem_we_in = v.collide && !collided && busy_out && (mem_raddr_out == v.we_addr);
            if (mem_we_in) collided = 1;
            start_in = v.spur && (cyc == 3);
            if (start_in) begin
                base_addr_in = 10'h200;
                count_in     = 11'd7;
            end
            @(negedge clk);
            if (stalled) begin
                check({v.name, "_stall_valid"}, 32'(sif.m_valid_out), 32'd1);
                check({v.name, "_stall_data"},  sif.m_data_out, held);
            end
            if (sif.m_valid_out && sif.m_ready_in) begin
                if (first_valid < 0) first_valid = cyc;
                beats++;
                if (exp_q.size() == 0) begin
                    check({v.name, "_extra_beat"}, sif.m_data_out, 32'hFFFF_FFFF);
                end else begin
                    check({v.name, "_data"}, sif.m_data_out, exp_q.pop_front());
                    check({v.name, "_last"}, 32'(sif.m_last_out), 32'(exp_q.size() == 0));
                end
            end
            stalled = sif.m_valid_out && !sif.m_ready_in;
            held    = sif.m_data_out;
            if (done_out) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        start_in       = 1'b0;
        mem_we_in      = 1'b0;
        sif.m_ready_in = 1'b1;
        check({v.name, "_first_valid"}, 32'(first_valid), 32'(v.exp_first));
        check({v.name, "_done_cycle"},  32'(done_cyc),    32'(v.exp_done));
        check({v.name, "_beats"},       32'(beats),       32'(v.count));
        check({v.name, "_busy_after"},  32'(busy_out),    32'd0);
        check({v.name, "_done_pulse"},  32'(done_out),    32'd0);
        if (!v.collide) begin
            for (int k = 0; k < 4 && k < int'(v.count); k++) begin
                a = v.base + 10'(k);
                check({v.name, "_raddr"}, 32'(raddr_seen[k]), 32'(a));
            end
        end
    endtask

    task automatic reset_mid_stream();
        int   hs = 0;
        int   cyc = 0;
        vec_t v;

        base_addr_in   = 10'h010;
        count_in       = 11'd4;
        start_in       = 1'b1;
        sif.m_ready_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        while (hs < 2 && cyc < 20) begin
            @(negedge clk);
            if (sif.m_valid_out && sif.m_ready_in) hs++;
            if (hs < 2) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        check("rst_pre_beats", 32'(hs), 32'd2);
        #1 rstn = 1'b0;
        #1 check_idle_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        v = '{name: "after_rst", base: 10'h000, count: 11'd2, collide: 0, we_addr: 10'h0,
              ready_mode: 0, spur: 0, exp_first: 3, exp_done: 5};
        run_cmd(v);
    endtask

    vec_t vecs[8];

    initial begin
        rstn           = 1'b0;
        start_in       = 1'b0;
        base_addr_in   = '0;
        count_in       = '0;
        mem_we_in      = 1'b0;
        sif.m_ready_in = 1'b1;

        vecs[0] = '{name: "basic",      base: 10'h010, count: 11'd4,  collide: 0, we_addr: 10'h0,
                    ready_mode: 0, spur: 0, exp_first: 3,  exp_done: 7};
        vecs[1] = '{name: "backpress",  base: 10'h010, count: 11'd4,  collide: 0, we_addr: 10'h0,
                    ready_mode: 1, spur: 0, exp_first: 8,  exp_done: 12};
        vecs[2] = '{name: "collide",    base: 10'h010, count: 11'd4,  collide: 1, we_addr: 10'h011,
                    ready_mode: 0, spur: 0, exp_first: 3,  exp_done: 8};
        vecs[3] = '{name: "wrap",       base: 10'h3FE, count: 11'd4,  collide: 0, we_addr: 10'h0,
                    ready_mode: 0, spur: 0, exp_first: 3,  exp_done: 7};
        vecs[4] = '{name: "zero",       base: 10'h055, count: 11'd0,  collide: 0, we_addr: 10'h0,
                    ready_mode: 0, spur: 0, exp_first: -1, exp_done: 1};
        vecs[5] = '{name: "spur_start", base: 10'h010, count: 11'd4,  collide: 0, we_addr: 10'h0,
                    ready_mode: 0, spur: 1, exp_first: 3,  exp_done: 7};
        vecs[6] = '{name: "long_stall", base: 10'h100, count: 11'd10, collide: 0, we_addr: 10'h0,
                    ready_mode: 1, spur: 0, exp_first: 8,  exp_done: 18};
        vecs[7] = '{name: "long_wrap",  base: 10'h3FA, count: 11'd10, collide: 0, we_addr: 10'h0,
                    ready_mode: 0, spur: 0, exp_first: 3,  exp_done: 13};

        #1 check_idle_outputs("reset");
        #12;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);
        reset_mid_stream();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/output_bank_drainer.md
# output_bank_drainer

Read-side controller for a banked output memory: on a start command it sweeps a contiguous address range through the memory's single read port and streams the words out over a valid/ready interface. It sits between the systolic array's output memory and the result/host streaming path. It handles the one-cycle registered read latency and the memory's read-suppressed-on-write behaviour, so downstream logic sees a clean, ordered, lossless stream.

## Interface
- RAM_WIDTH, 32, data word width (matches memory)
- RAM_ADDR_BITS, 10, memory address width
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥3 for full throughput)

Reset is asynchronous, active-low.

- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start_in  input  1  command strobe, accepted only in IDLE
- base_addr_in  input  RAM_ADDR_BITS  first address, sampled with start_in
- count_in  input  RAM_ADDR_BITS+1  words to drain (0..2^RAM_ADDR_BITS), sampled with start_in
- busy_out  output  1  command in progress
- done_out  output  1  one-cycle completion pulse
- mem_raddr_out  output  RAM_ADDR_BITS  memory read address (registered)
- mem_we_in  input  1  memory write-enable as driven by the producer; high means this cycle's read is lost
- mem_rdata_in  input  RAM_WIDTH  memory read data
- m_valid_out  output  1  stream word valid
- m_ready_in  input  1  stream consumer ready
- m_data_out  output  RAM_WIDTH  stream word
- m_last_out  output  1  marks final word of the command

## Operation
- States: IDLE, RUN (reads being issued), FLUSH (all reads captured, FIFO draining), DONE (one cycle).
- IDLE + start_in, count≠0 → RUN; count=0 → DONE directly. start_in outside IDLE is ignored.
- RUN: a read is issued in a cycle when credit = FIFO_DEPTH − fifo_count − inflight > 0. inflight is 1 if a read was captured last cycle. A read at address A issued in cycle t captures iff mem_we_in=0 in cycle t.
  - On capture, data is valid on mem_rdata_in in cycle t+1 and is pushed into the FIFO at the end of t+1. The address then advances.
  - If mem_we_in=1, the read is lost and the same address is reissued. Order is always preserved.
- Address increments modulo 2^RAM_ADDR_BITS (wrap 0x3FF→0x000).
- All count reads captured → FLUSH. FIFO empty and the last beat accepted → DONE → IDLE.
- m_last_out=1 only with the count-th word.
- Outputs are held stable while m_valid_out=1 and m_ready_in=0.

## Timing
- Reset values: busy_out=0, done_out=0, mem_raddr_out=0, m_valid_out=0, m_data_out=0, m_last_out=0. FIFO empty, state IDLE.
- Reset asserted mid-command clears everything immediately. In-flight data is discarded.
- start accepted in cycle 0 → mem_raddr_out=base in cycle 1 → first m_valid_out in cycle 3.
- Throughput is 1 word/cycle with m_ready_in=1 and mem_we_in=0. Each lost read costs one bubble.
- busy_out is high from cycle 1 through the DONE cycle.
- done_out is high in the cycle after the last beat handshake; busy_out drops with it.
- count=0: done_out in cycle 1, no beats.
- Simultaneous FIFO push and pop in one cycle leaves the count unchanged.
- Never more than FIFO_DEPTH words are buffered or in flight.

## Structure
- Package mem_drain_pkg: state enum typedef (IDLE/RUN/FLUSH/DONE), count-width localparam helper.
- Sub-module drain_fifo: synchronous FIFO with push/pop/count and async active-low clear.
- The top level holds the FSM, address/remaining counters and the credit logic.

## Test plan
- Basic drain: mem[k]=k*0x11, base=0x010, count=4, ready=1.
  - Required: beats 0x110, 0x121, 0x132, 0x143 in cycles 3–6, last on the 4th, done in cycle 7.
- Backpressure: same command, ready low for 5 cycles after the first valid.
  - Required: ≤4 reads outstanding, m_data_out stable while stalled, all 4 words delivered in order.
- Write collision: mem_we_in=1 in the issue cycle of address 0x011.
  - Required: 0x011 is reissued, stream stays 0x110, 0x121, …, one bubble, done one cycle later.
- Wrap: base=0x3FE, count=4.
  - Required: mem_raddr_out sequence 0x3FE, 0x3FF, 0x000, 0x001; data is in matching order.
- Degenerate cases: count=0 gives no valid beats and done in cycle 1. A start_in pulsed while busy is ignored, with the original stream unaffected.
- Reset mid-stream: rstn low after 2 beats.
  - Required: all outputs 0 at once. A new start (base=0, count=2) drains correctly with no stale words.
